// File: rtl/fft_vis_pkg.sv
// Shared types and constants for the FFT spectrum renderer.
package fft_vis_pkg;

    localparam int unsigned PIX_W = 10;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StPeakScan
    } state_e;

    typedef enum logic [1:0] {
        ColBlack,
        ColWhite,
        ColBlue,
        ColRed
    } colour_e;

endpackage

// File: rtl/fft_height_scaler.sv
// Registered magnitude-to-height conversion: linear right shift or log2 octave steps,
// saturated to the last visible row.
module fft_height_scaler #(
    parameter int unsigned MAG_W     = 24,
    parameter int unsigned MAG_SHIFT = 10,
    parameter int unsigned LOG_STEP  = 20,
    parameter int unsigned V_RES     = 480,
    parameter int unsigned HW        = $clog2(V_RES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_log,
    input  logic [MAG_W-1:0] i_mag,
    output logic [HW-1:0]    o_h
);
    localparam int               H_MAX   = int'(V_RES) - 1;
    localparam logic [MAG_W-1:0] H_MAX_M = MAG_W'(H_MAX);

    logic [MAG_W-1:0] lin;
    int               msb_p1;
    int               log_h;
    logic [HW-1:0]    h_d;
    logic [HW-1:0]    h_q;

    always_comb begin
        lin    = i_mag >> MAG_SHIFT;
        msb_p1 = 0;
        for (int i = 0; i < int'(MAG_W); i++) begin
            if (i_mag[i]) msb_p1 = i + 1;
        end
        // A zero magnitude leaves msb_p1 at 0, so it maps to height 0.
        log_h = msb_p1 * int'(LOG_STEP);
        if (i_log) begin
            h_d = (log_h > H_MAX) ? HW'(H_MAX) : HW'(log_h);
        end else begin
            h_d = (lin > H_MAX_M) ? HW'(H_MAX) : HW'(lin);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
        end else if (i_en) begin
            h_q <= h_d;
        end
    end

    assign o_h = h_q;

endmodule

// File: rtl/fft_spectrum_renderer.sv
// FFT magnitude bar-graph renderer: double-buffered height RAM, peak-hold RAM with decay,
// and a fixed 3-stage pixel pipeline feeding the VGA colour outputs.
module fft_spectrum_renderer
    import fft_vis_pkg::*;
#(
    parameter int unsigned N_BINS     = 512,
    parameter int unsigned MAG_W      = 24,
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned BAR_W      = 1,
    parameter int unsigned MAG_SHIFT  = 10,
    parameter int unsigned LOG_STEP   = 20,
    parameter int unsigned PEAK_DECAY = 1,
    parameter int unsigned COLOR_W    = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [$clog2(N_BINS)-1:0] i_bin_addr,
    input  logic [MAG_W-1:0]          i_bin_mag,
    input  logic                      i_bin_valid,
    input  logic                      i_bin_last,
    input  logic                      i_mode,
    input  logic                      i_peak_en,
    input  logic                      i_frame_over,
    input  logic [PIX_W-1:0]          i_pixel_x,
    input  logic [PIX_W-1:0]          i_pixel_y,
    input  logic                      i_video_on,
    output logic [COLOR_W-1:0]        o_vga_r,
    output logic [COLOR_W-1:0]        o_vga_g,
    output logic [COLOR_W-1:0]        o_vga_b,
    output logic                      o_overrun,
    output logic                      o_busy
);
    localparam int unsigned AW     = $clog2(N_BINS);
    localparam int unsigned HW     = $clog2(V_RES);
    localparam int unsigned BAR_SH = $clog2(BAR_W);
    localparam int unsigned SPAN   = N_BINS * BAR_W;
    localparam int unsigned MARGIN = (H_RES - SPAN) / 2;

    localparam logic [PIX_W-1:0] X_LO   = PIX_W'(MARGIN);
    localparam logic [PIX_W-1:0] X_HI   = PIX_W'(MARGIN + SPAN);
    localparam logic [PIX_W-1:0] Y_LAST = PIX_W'(V_RES - 1);
    localparam logic [HW-1:0]    DECAY  = HW'(PEAK_DECAY);

    logic          accept;
    logic          swap;
    logic          eff_mode;
    logic          mode_q, mode_d;
    logic          frame_ready_q, frame_ready_d;
    logic          overrun_q, overrun_d;
    logic          rd_bank_q, rd_bank_d;
    logic          wr_valid_q;
    logic [AW-1:0] wr_addr_q;
    logic [HW-1:0] wr_h;
    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic [HW-1:0] h_mem  [2*N_BINS];
    logic [HW-1:0] pk_mem [N_BINS];
    logic [HW-1:0] h_rd_q, pk_rd_q;
    logic          pk_we;
    logic [AW-1:0] pk_waddr;
    logic [HW-1:0] pk_wdata, pk_dec;

    logic             busy, in_range;
    logic [PIX_W-1:0] rel_x;
    logic [AW-1:0]    pix_bin, rd_addr;
    logic             s1_in_q, s1_busy_q, s1_von_q;
    logic [PIX_W-1:0] s1_y_q, s2_y_q;
    logic             s2_von_q, s2_pen_q;
    logic [HW-1:0]    s2_h_q, s2_pk_q;
    logic [PIX_W-1:0] bar_top, pk_row;
    colour_e          col_q, col_d;

    // Once a frame is complete, its bank is frozen until the vsync swap.
    assign accept   = i_bin_valid & ~frame_ready_q;
    assign eff_mode = (i_bin_addr == '0) ? i_mode : mode_q;
    assign swap     = i_frame_over & frame_ready_q & (state_q == StIdle);

    always_comb begin
        mode_d        = mode_q;
        frame_ready_d = frame_ready_q;
        overrun_d     = overrun_q | (i_bin_valid & frame_ready_q);
        rd_bank_d     = rd_bank_q;
        if (accept && i_bin_addr == '0) mode_d = i_mode;
        if (accept && i_bin_last) frame_ready_d = 1'b1;
        if (swap) begin
            frame_ready_d = 1'b0;
            rd_bank_d     = ~rd_bank_q;
        end
    end

    fft_height_scaler #(
        .MAG_W     (MAG_W),
        .MAG_SHIFT (MAG_SHIFT),
        .LOG_STEP  (LOG_STEP),
        .V_RES     (V_RES),
        .HW        (HW)
    ) u_scaler (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (accept),
        .i_log (eff_mode),
        .i_mag (i_bin_mag),
        .o_h   (wr_h)
    );

    // Scan reads bin cnt while writing back bin cnt-1, hence N_BINS+1 cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pk_we    = 1'b0;
        pk_waddr = cnt_q[AW-1:0];
        pk_wdata = '0;
        pk_dec   = (pk_rd_q > DECAY) ? pk_rd_q - DECAY : '0;
        unique case (state_q)
            StInit: begin
                pk_we = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == (AW+1)'(N_BINS - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StIdle: begin
                if (swap) begin
                    state_d = StPeakScan;
                    cnt_d   = '0;
                end
            end
            StPeakScan: begin
                pk_we    = (cnt_q != '0);
                pk_waddr = AW'(cnt_q - 1'b1);
                if (i_peak_en) pk_wdata = (h_rd_q > pk_dec) ? h_rd_q : pk_dec;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == (AW+1)'(N_BINS)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: state_d = StInit;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign in_range = (i_pixel_x >= X_LO) && (i_pixel_x < X_HI);
    assign rel_x    = i_pixel_x - X_LO;
    assign pix_bin  = AW'(rel_x >> BAR_SH);
    assign rd_addr  = busy ? cnt_q[AW-1:0] : pix_bin;

    always_ff @(posedge clk) begin
        if (wr_valid_q) h_mem[{~rd_bank_q, wr_addr_q}] <= wr_h;
        if (pk_we) pk_mem[pk_waddr] <= pk_wdata;
        h_rd_q  <= h_mem[{rd_bank_q, rd_addr}];
        pk_rd_q <= pk_mem[rd_addr];
    end

    always_comb begin
        bar_top = Y_LAST - PIX_W'(s2_h_q);
        pk_row  = Y_LAST - PIX_W'(s2_pk_q);
        if (!s2_von_q || s2_y_q == Y_LAST) begin
            col_d = ColBlack;
        end else if (s2_pen_q && s2_pk_q != '0 && s2_y_q == pk_row) begin
            col_d = ColRed;
        end else if (s2_h_q != '0 && s2_y_q >= bar_top && s2_y_q < Y_LAST) begin
            col_d = ColBlue;
        end else begin
            col_d = ColWhite;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= 1'b0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            state_q       <= StInit;
            cnt_q         <= '0;
            s1_in_q       <= 1'b0;
            s1_busy_q     <= 1'b0;
            s1_von_q      <= 1'b0;
            s1_y_q        <= '0;
            s2_von_q      <= 1'b0;
            s2_pen_q      <= 1'b0;
            s2_y_q        <= '0;
            s2_h_q        <= '0;
            s2_pk_q       <= '0;
            col_q         <= ColBlack;
        end else begin
            mode_q        <= mode_d;
            frame_ready_q <= frame_ready_d;
            overrun_q     <= overrun_d;
            rd_bank_q     <= rd_bank_d;
            wr_valid_q    <= accept;
            wr_addr_q     <= i_bin_addr;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            s1_in_q       <= in_range;
            s1_busy_q     <= busy;
            s1_von_q      <= i_video_on;
            s1_y_q        <= i_pixel_y;
            s2_von_q      <= s1_von_q;
            s2_pen_q      <= i_peak_en;
            s2_y_q        <= s1_y_q;
            s2_h_q        <= (s1_in_q && !s1_busy_q) ? h_rd_q : '0;
            s2_pk_q       <= (s1_in_q && !s1_busy_q) ? pk_rd_q : '0;
            col_q         <= col_d;
        end
    end

    assign o_vga_r   = (col_q == ColWhite || col_q == ColRed) ? '1 : '0;
    assign o_vga_g   = (col_q == ColWhite) ? '1 : '0;
    assign o_vga_b   = (col_q == ColWhite || col_q == ColBlue) ? '1 : '0;
    assign o_overrun = overrun_q;
    assign o_busy    = busy;

endmodule

// File: tb/tb_fft_spectrum_renderer.sv
// Directed bench for fft_spectrum_renderer; pixel results are checked through a scoreboard
// that mirrors the 3-cycle render latency.
module tb_fft_spectrum_renderer;

    localparam logic [29:0] BLACK = 30'h0;
    localparam logic [29:0] WHITE = 30'h3FFF_FFFF;
    localparam logic [29:0] BLUE  = 30'h0000_03FF;
    localparam logic [29:0] RED   = 30'h3FF0_0000;

    typedef struct {
        string       tag;
        logic [29:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  i_bin_addr = '0;
    logic [23:0] i_bin_mag = '0;
    logic        i_bin_valid = 1'b0;
    logic        i_bin_last = 1'b0;
    logic        i_mode = 1'b0;
    logic        i_peak_en = 1'b0;
    logic        i_frame_over = 1'b0;
    logic [9:0]  i_pixel_x = '0;
    logic [9:0]  i_pixel_y = '0;
    logic        i_video_on = 1'b0;
    logic [9:0]  o_vga_r, o_vga_g, o_vga_b;
    logic        o_overrun, o_busy;

    exp_t        sb[$];
    logic [2:0]  chk_pipe = '0;
    logic        drv_chk = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n;

    fft_spectrum_renderer u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_bin_addr   (i_bin_addr),
        .i_bin_mag    (i_bin_mag),
        .i_bin_valid  (i_bin_valid),
        .i_bin_last   (i_bin_last),
        .i_mode       (i_mode),
        .i_peak_en    (i_peak_en),
        .i_frame_over (i_frame_over),
        .i_pixel_x    (i_pixel_x),
        .i_pixel_y    (i_pixel_y),
        .i_video_on   (i_video_on),
        .o_vga_r      (o_vga_r),
        .o_vga_g      (o_vga_g),
        .o_vga_b      (o_vga_b),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        chk_pipe = {chk_pipe[1:0], drv_chk};
        @(negedge clk);
        if (chk_pipe[2]) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_bad++;
                $error("FAIL scoreboard_empty: observed %h expected entry", {o_vga_r, o_vga_g, o_vga_b});
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                assert ({o_vga_r, o_vga_g, o_vga_b} === e.rgb) else begin
                    n_bad++;
                    $error("FAIL %s: observed %h expected %h", e.tag,
                           {o_vga_r, o_vga_g, o_vga_b}, e.rgb);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic wr(input int addr, input int mag, input bit last, input bit mode);
        i_bin_valid = 1'b1;
        i_bin_addr  = 9'(addr);
        i_bin_mag   = 24'(mag);
        i_bin_last  = last;
        i_mode      = mode;
        cyc();
        i_bin_valid = 1'b0;
        i_bin_last  = 1'b0;
    endtask

    task automatic fover();
        i_frame_over = 1'b1;
        cyc();
        i_frame_over = 1'b0;
    endtask

    task automatic busy_len(output int cnt);
        cnt = 0;
        while (o_busy && cnt < 2000) begin
            cyc();
            cnt++;
        end
    endtask

    task automatic pix(input string tag, input int x, input int y, input bit von,
                       input logic [29:0] rgb);
        i_pixel_x  = 10'(x);
        i_pixel_y  = 10'(y);
        i_video_on = von;
        drv_chk    = 1'b1;
        sb.push_back('{tag, rgb});
        cyc();
    endtask

    task automatic drain();
        drv_chk = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_rgb", int'({o_vga_r, o_vga_g, o_vga_b}), 0);
        chk("rst_overrun", int'(o_overrun), 0);
        chk("rst_busy", int'(o_busy), 1);
        rst_n = 1'b1;
        busy_len(n);
        chk("init_len", n, 512);

        // Linear mode, bin 5 saturates to full height.
        wr(0, 0, 1'b0, 1'b0);
        wr(5, 480 << 10, 1'b1, 1'b0);
        fover();
        busy_len(n);
        chk("scan_len_lin", n, 513);
        pix("lin_y0", 69, 0, 1'b1, BLUE);
        pix("lin_y200", 69, 200, 1'b1, BLUE);
        pix("lin_y478", 69, 478, 1'b1, BLUE);
        pix("lin_border", 69, 479, 1'b1, BLACK);
        pix("lin_left_out", 63, 200, 1'b1, WHITE);
        pix("lin_right_out", 576, 200, 1'b1, WHITE);
        pix("lin_bin0_empty", 64, 478, 1'b1, WHITE);
        pix("lin_blank", 69, 200, 1'b0, BLACK);
        drain();

        // Log mode latched on bin 0; later bins drive i_mode low.
        wr(0, 0, 1'b0, 1'b1);
        wr(7, 24'h000400, 1'b0, 1'b0);
        wr(8, 0, 1'b0, 1'b0);
        wr(9, 24'hFFFFFF, 1'b1, 1'b0);
        fover();
        busy_len(n);
        chk("scan_len_log", n, 513);
        pix("log_b7_top", 71, 259, 1'b1, BLUE);
        pix("log_b7_above", 71, 258, 1'b1, WHITE);
        pix("log_b8_zero", 72, 478, 1'b1, WHITE);
        pix("log_b9_sat", 73, 0, 1'b1, BLUE);
        drain();

        // Frame A completes, frame B must be dropped.
        wr(0, 0, 1'b0, 1'b0);
        wr(11, 300 << 10, 1'b1, 1'b0);
        chk("overrun_before", int'(o_overrun), 0);
        wr(0, 0, 1'b0, 1'b0);
        wr(11, 50 << 10, 1'b1, 1'b0);
        chk("overrun_after", int'(o_overrun), 1);
        fover();
        busy_len(n);
        chk("scan_len_gate", n, 513);
        pix("gate_a_top", 75, 179, 1'b1, BLUE);
        pix("gate_a_above", 75, 178, 1'b1, WHITE);
        drain();

        // Peak hold with decay.
        i_peak_en = 1'b1;
        wr(0, 0, 1'b0, 1'b0);
        wr(10, 100 << 10, 1'b1, 1'b0);
        fover();
        busy_len(n);
        chk("scan_len_pk1", n, 513);
        pix("pk1_marker", 74, 379, 1'b1, RED);
        pix("pk1_bar", 74, 380, 1'b1, BLUE);
        pix("pk1_above", 74, 378, 1'b1, WHITE);
        drain();
        wr(0, 0, 1'b0, 1'b0);
        wr(10, 0, 1'b1, 1'b0);
        fover();
        busy_len(n);
        chk("scan_len_pk2", n, 513);
        pix("pk2_decayed", 74, 380, 1'b1, RED);
        pix("pk2_old_row", 74, 379, 1'b1, WHITE);
        pix("pk2_below", 74, 381, 1'b1, WHITE);
        drain();
        i_peak_en = 1'b0;
        cyc();
        pix("pk_disabled", 74, 380, 1'b1, WHITE);
        drain();

        // Last bin and vsync together: no swap until the next tick.
        wr(0, 0, 1'b0, 1'b0);
        i_frame_over = 1'b1;
        wr(12, 200 << 10, 1'b1, 1'b0);
        i_frame_over = 1'b0;
        chk("same_cycle_no_scan", int'(o_busy), 0);
        cyc();
        chk("same_cycle_still_idle", int'(o_busy), 0);
        fover();
        // A complete frame and vsync arriving mid-scan must wait for IDLE.
        wr(0, 0, 1'b0, 1'b0);
        wr(13, 150 << 10, 1'b1, 1'b0);
        fover();
        busy_len(n);
        chk("scan_len_deferred", n, 510);
        cyc();
        chk("deferred_no_autoscan", int'(o_busy), 0);
        pix("deferred_old_bank", 76, 279, 1'b1, BLUE);
        pix("deferred_old_above", 76, 278, 1'b1, WHITE);
        drain();
        fover();
        busy_len(n);
        chk("scan_len_late_swap", n, 513);
        pix("late_swap_b13", 77, 329, 1'b1, BLUE);
        drain();

        // Reset mid-scan after building a nonzero peak on bin 10.
        i_peak_en = 1'b1;
        wr(0, 0, 1'b0, 1'b0);
        wr(10, 100 << 10, 1'b1, 1'b0);
        fover();
        busy_len(n);
        chk("scan_len_pre_rst", n, 513);
        wr(0, 0, 1'b0, 1'b0);
        wr(10, 0, 1'b1, 1'b0);
        i_pixel_x  = 10'd77;
        i_pixel_y  = 10'd329;
        i_video_on = 1'b1;
        fover();
        repeat (100) cyc();
        rst_n = 1'b0;
        #1;
        chk("midscan_rst_rgb", int'({o_vga_r, o_vga_g, o_vga_b}), 0);
        chk("midscan_rst_overrun", int'(o_overrun), 0);
        chk("midscan_rst_busy", int'(o_busy), 1);
        cyc();
        cyc();
        rst_n = 1'b1;
        busy_len(n);
        chk("reinit_len", n, 512);
        wr(0, 0, 1'b0, 1'b0);
        wr(10, 0, 1'b1, 1'b0);
        fover();
        busy_len(n);
        chk("scan_len_post_rst", n, 513);
        pix("post_rst_y379", 74, 379, 1'b1, WHITE);
        pix("post_rst_y380", 74, 380, 1'b1, WHITE);
        pix("post_rst_y381", 74, 381, 1'b1, WHITE);
        drain();

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
